mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences the shared memory, instruction register, register file, ALU and PC update across fetch, decode, execute, memory and writeback. Each instruction takes a variable number of cycles. It sits between the instruction register's opcode field and the datapath enables and mux selects, and stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state encoding and of the debug state output.
- FETCH_TIMEOUT, 15, maximum number of consecutive cycles spent waiting on mem_ready in any memory state before err_timeout fires.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26], taken from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC register enable, equal to pc_write | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct, 11 = unused.
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- err_timeout  out  1  one-cycle pulse when mem_ready times out.
- state  out  STATE_W  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Encodings 12-15 are unreachable. If ever entered, the FSM returns to FETCH on the next edge.
- Reset: on any edge with rst=1 the state becomes FETCH and the wait counter clears to 0. Reset is honoured mid-instruction and mid-wait.
- Outputs are combinational decodes of the state, plus mem_ready and zero where listed below. Every output not listed for a state is 0.
- When rst=1, pc_en, ir_write, reg_write and mem_write are forced to 0.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - Drives ir_write=mem_ready and pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then moves to DECODE. The PC therefore advances exactly once per fetch.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 to precompute the branch target.
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH with illegal=1 for this cycle.
- MEMADR: drives alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: drives mem_read=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: drives reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEMWR: drives mem_write=1, iord=1. Holds until mem_ready, then goes to FETCH.
- EXECUTE: drives alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
  - pc_en=zero.
  - Goes to FETCH.
- ADDIEX: drives alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: drives pc_src=10, pc_write=1. Goes to FETCH.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change.
- Timeout:
  - When the counter reaches FETCH_TIMEOUT, err_timeout pulses for 1 cycle.
  - The FSM then forces state to FETCH and clears the counter. This abandons a pending MEMRD or MEMWR with no reg_write or mem_write side effect.
- Latency (with mem_ready tied to 1):
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - beq: 3 cycles.
  - addi: 4 cycles.
  - j: 3 cycles.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- When defined:
  - Opcode 000101 (bne) in DECODE goes to state BNE=12.
  - BNE drives the same outputs as BRANCH, except pc_en=~zero.
  - BNE then goes to FETCH.
- When undefined, opcode 000101 is illegal.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum/localparams;
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - the alu_op, alu_src_b and pc_src encodings.
- One sub-module is natural: mips_ctrl_outdec, the purely combinational state-to-control-signal decoder. The FSM register, next-state logic and wait counter stay in the top module.

Test Plan:
- Reset and fetch: rst=1 for 2 cycles, then mem_ready low for 3 cycles, then high. Required: state=0 throughout; ir_write and pc_en assert only in the mem_ready cycle; state=1 on the next cycle.
- lw: opcode=100011, mem_ready=1. Required: states 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1, reg_dst=0.
- beq: opcode=000100, run once with zero=1 and once with zero=0. Required: in state 8, pc_en=1 with pc_src=01 for zero=1, and pc_en=0 for zero=0.
- Illegal opcode: opcode=111111. Required: illegal=1 exactly in the DECODE cycle, then FETCH; no reg_write or mem_write at any point.
- Timeout: sw with mem_ready held at 0 in MEMWR for 15 cycles. Required: err_timeout pulses once, state returns to 0, mem_write deasserts.
- Reset mid-instruction: assert rst in ALUWB. Required: reg_write=0 that cycle and state=0 on the next edge. With MIPS_CTRL_BNE_EN defined, bne with zero=0 gives pc_en=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and control-field encodings for the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_BNE
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
  function automatic logic is_wait(state_t s);
    return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
  endfunction
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: state to datapath control decode (BNE decode under MIPS_CTRL_BNE_EN)
module mips_ctrl_outdec import mips_ctrl_pkg::*; (
  input  state_t     st,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       rst,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src
);
  logic pc_write, branch, take, irw, rw, mw;
  // per-state control decode; write strobes are masked while in reset
  always_comb begin
    iord = 1'b0;
    mem_read = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    rw = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    alu_op = ALU_ADD;
    pc_src = PC_ALU;
    pc_write = 1'b0;
    branch = 1'b0;
    take = zero;
    case (st)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = SRCB_4;
        irw = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord = 1'b1;
      end
      S_MEMWB: begin
        rw = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mw = 1'b1;
        iord = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        rw = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_src = PC_ALUOUT;
        branch = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_src = PC_ALUOUT;
        branch = 1'b1;
        take = ~zero;
      end
`endif
      S_ADDIWB: rw = 1'b1;
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  assign pc_en = ~rst & (pc_write | (branch & take));
  assign ir_write = ~rst & irw;
  assign reg_write = ~rst & rw;
  assign mem_write = ~rst & mw;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main control FSM with mem_ready timeout (bne via MIPS_CTRL_BNE_EN)
module mips_multicycle_ctrl import mips_ctrl_pkg::*; #(
  parameter int STATE_W = 4,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic               err_timeout,
  output logic [STATE_W-1:0] state
);
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic tmo;
  // timeout fires on the last tolerated stalled cycle, so the abandoned access never completes
  assign tmo = is_wait(st) && !mem_ready && cnt == CW'(FETCH_TIMEOUT - 1);
  assign err_timeout = tmo;
  assign state = STATE_W'(st);
  // state register and stall counter; the counter only survives a stay in a wait state
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_FETCH;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= (nxt == st && is_wait(st) && !tmo) ? cnt + 1'b1 : '0;
    end
  end
  // next-state selection; opcode stays valid in the IR for the whole instruction
  always_comb begin
    nxt = S_FETCH;
    illegal = 1'b0;
    case (st)
      S_FETCH: nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE: nxt = S_EXECUTE;
          OP_BEQ: nxt = S_BRANCH;
          OP_ADDI: nxt = S_ADDIEX;
          OP_J: nxt = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE: nxt = S_BNE;
`endif
          default: illegal = 1'b1;
        endcase
      S_MEMADR: nxt = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD: nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      default: nxt = S_FETCH;
    endcase
    if (tmo) nxt = S_FETCH;
  end
  mips_ctrl_outdec u_dec (
    .st(st), .zero(zero), .mem_ready(mem_ready), .rst(rst),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src)
  );
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: instruction-level reference model check of the multicycle MIPS controller
module tb_mips_multicycle_ctrl;
  localparam int TO = 15;
`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic illegal, err_timeout;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [20:0] act, exp;
  logic [12:0] tab [16];
  logic [12:0] t;
  logic [5:0] ops [7];
  logic e_ill, e_tmo, e_pe, e_irw;
  int errs = 0, checks = 0;
  int m_st = 0, m_wait = 0;
  int q[$];
  bit armed = 1'b0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl #(.STATE_W(4), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal(illegal),
    .err_timeout(err_timeout), .state(state)
  );
  assign act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, illegal, err_timeout, state};
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit legal(logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP || (BNE_EN && op == BNE);
  endfunction
  function automatic bit is_mem(int s);
    return s == 0 || s == 3 || s == 5;
  endfunction
  // model: the remaining states of an instruction are queued when it is decoded
  always @(posedge clk) begin
    if (rst) begin
      m_st = 0;
      m_wait = 0;
      q.delete();
      armed = 1'b1;
    end else if (is_mem(m_st) && !mem_ready && m_wait == TO - 1) begin
      m_st = 0;
      m_wait = 0;
      q.delete();
    end else if (is_mem(m_st) && !mem_ready) begin
      m_wait++;
    end else begin
      m_wait = 0;
      if (m_st == 0) m_st = 1;
      else begin
        if (m_st == 1) begin
          q.delete();
          if (opcode == LW) q = '{2, 3, 4};
          else if (opcode == SW) q = '{2, 5};
          else if (opcode == RT) q = '{6, 7};
          else if (opcode == BEQ) q = '{8};
          else if (opcode == ADDI) q = '{9, 10};
          else if (opcode == JMP) q = '{11};
          else if (BNE_EN && opcode == BNE) q = '{12};
        end
        if (q.size() != 0) m_st = q.pop_front();
        else m_st = 0;
      end
    end
  end
  // compare every cycle against the model, mid-way between edges
  always @(negedge clk) begin
    #2;
    if (armed) begin
      t = tab[m_st];
      e_ill = m_st == 1 && !legal(opcode);
      e_tmo = is_mem(m_st) && !mem_ready && m_wait == TO - 1;
      e_irw = !rst && m_st == 0 && mem_ready;
      e_pe = !rst && ((m_st == 0 && mem_ready) || m_st == 11 || (m_st == 8 && zero) ||
                      (m_st == 12 && BNE_EN && !zero));
      exp = {e_pe, t[12], t[11], t[10] & !rst, e_irw, t[9], t[8], t[7] & !rst, t[6],
             t[5:4], t[3:2], t[1:0], e_ill, e_tmo, 4'(m_st)};
      chk("cycle outputs", act, exp);
    end
  end
  task automatic step(logic r, logic [5:0] op, logic z, logic rd);
    @(negedge clk);
    rst = r;
    opcode = op;
    zero = z;
    mem_ready = rd;
    #2;
  endtask
  initial begin
    logic [5:0] op;
    bit stall;
    // {iord, mem_read, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src}
    foreach (tab[i]) tab[i] = 13'd0;
    tab[0]  = 13'b0_1_0_0_0_0_0_01_00_00;
    tab[1]  = 13'b0_0_0_0_0_0_0_11_00_00;
    tab[2]  = 13'b0_0_0_0_0_0_1_10_00_00;
    tab[3]  = 13'b1_1_0_0_0_0_0_00_00_00;
    tab[4]  = 13'b0_0_0_0_1_1_0_00_00_00;
    tab[5]  = 13'b1_0_1_0_0_0_0_00_00_00;
    tab[6]  = 13'b0_0_0_0_0_0_1_00_10_00;
    tab[7]  = 13'b0_0_0_1_0_1_0_00_00_00;
    tab[8]  = 13'b0_0_0_0_0_0_1_00_01_01;
    tab[9]  = 13'b0_0_0_0_0_0_1_10_00_00;
    tab[10] = 13'b0_0_0_0_0_1_0_00_00_00;
    tab[11] = 13'b0_0_0_0_0_0_0_00_00_10;
    tab[12] = BNE_EN ? tab[8] : 13'd0;
    ops = '{LW, SW, RT, BEQ, BNE, ADDI, JMP};
    step(1, LW, 0, 0);
    step(1, LW, 0, 0);
    chk("reset state", state, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, LW, 0, 0);
      chk("fetch stall", {state, ir_write, pc_en}, {4'd0, 2'b00});
    end
    step(0, LW, 0, 1);
    chk("fetch ready", {state, ir_write, pc_en}, {4'd0, 2'b11});
    step(0, LW, 0, 1);
    chk("lw decode", state, 1);
    step(0, LW, 0, 1);
    chk("lw memadr", state, 2);
    step(0, LW, 0, 1);
    chk("lw memrd", state, 3);
    step(0, LW, 0, 1);
    chk("lw memwb", {state, reg_write, mem_to_reg, reg_dst}, {4'd4, 3'b110});
    step(0, BEQ, 1, 1);
    chk("lw done", state, 0);
    step(0, BEQ, 1, 1);
    step(0, BEQ, 1, 1);
    chk("beq taken", {state, pc_en, pc_src}, {4'd8, 1'b1, 2'b01});
    step(0, BEQ, 0, 1);
    step(0, BEQ, 0, 1);
    step(0, BEQ, 0, 1);
    chk("beq not taken", {state, pc_en}, {4'd8, 1'b0});
    step(0, 6'h3f, 0, 1);
    step(0, 6'h3f, 0, 1);
    chk("illegal decode", {state, illegal}, {4'd1, 1'b1});
    step(0, SW, 0, 1);
    chk("illegal done", {state, illegal}, {4'd0, 1'b0});
    step(0, SW, 0, 1);
    step(0, SW, 0, 1);
    chk("sw memadr", state, 2);
    for (int i = 0; i < TO; i++) begin
      step(0, SW, 0, 0);
      chk("sw stall", {state, mem_write, err_timeout}, {4'd5, 1'b1, 1'(i == TO - 1)});
    end
    step(0, SW, 0, 0);
    chk("after timeout", {state, mem_write, err_timeout}, {4'd0, 2'b00});
    step(0, RT, 0, 1);
    step(0, RT, 0, 1);
    step(0, RT, 0, 1);
    chk("rtype execute", state, 6);
    step(1, RT, 0, 1);
    chk("reset in aluwb", {state, reg_write}, {4'd7, 1'b0});
    step(0, BNE, 0, 1);
    chk("reset mid-instr", state, 0);
    step(0, BNE, 0, 1);
    chk("bne decode", {state, illegal}, {4'd1, !BNE_EN});
    step(0, BNE, 0, 1);
    chk("bne exec", {state, pc_en}, BNE_EN ? {4'd12, 1'b1} : {4'd0, 1'b1});
    op = LW;
    stall = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (m_st == 0) op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 49) == 0) stall = !stall;
      step($urandom_range(0, 299) == 0, op, 1'($urandom_range(0, 1)),
           stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
